// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC read sequencer and its phase timer.
package rtc_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_SETUP,
    ST_ADDR_STROBE,
    ST_ADDR_HOLD,
    ST_GAP,
    ST_DATA_STROBE,
    ST_DATA_HOLD,
    ST_WRITE
  } state_t;

  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic a_d;
    logic ad_oe;
  } bus_ctrl_t;

  // Bus released: no strobes, data phase selected, AD not driven.
  localparam bus_ctrl_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a_d: 1'b1, ad_oe: 1'b0};

  // Phase counter width: ceil(log2(t_phase)), never below one bit.
  function automatic int phase_w(input int t_phase);
    return (t_phase <= 2) ? 1 : $clog2(t_phase);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; 'last' marks the final cycle of a bus phase.
module rtc_phase_timer
  import rtc_pkg::*;
#(
  parameter int T_PHASE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic last
);

  localparam int CNT_W = phase_w(T_PHASE);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(T_PHASE - 1);

  logic [CNT_W-1:0] cnt;

  // Reload on state entry, then count down to the terminal count and park there.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/rtc_read_sequencer.sv
// Sweeps a block of RTC registers over the multiplexed AD bus and copies each
// byte into the output register bank.
//
// state          | meaning
// ---------------+-------------------------------------------------------
// ST_IDLE        | bus released, waiting for start
// ST_ADDR_SETUP  | address driven on AD, a_d low
// ST_ADDR_STROBE | address driven, cs_n and wr_n low (address latch)
// ST_ADDR_HOLD   | address still driven, strobes released
// ST_GAP         | AD released, turnaround before the read
// ST_DATA_STROBE | cs_n and rd_n low; ad_in captured on its last cycle
// ST_DATA_HOLD   | strobes released
// ST_WRITE       | one-cycle w_s to the bank, advance or finish
module rtc_read_sequencer
  import rtc_pkg::*;
#(
  parameter int          N_REGS    = 51,
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int          T_PHASE   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              a_d,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic [DATA_W-1:0] entrada,
  output logic [IDX_W-1:0]  enable,
  output logic              w_s,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] entrada_q;
  logic [IDX_W-1:0]  enable_q;
  logic              done_q;
  logic              phase_last;
  logic              phase_load;
  logic [DATA_W-1:0] rtc_addr;
  bus_ctrl_t         bus;

  // Address arithmetic wraps at 8 bits so a sweep may cross FFh -> 00h.
  assign rtc_addr = BASE_ADDR + {{(DATA_W - IDX_W){1'b0}}, idx};

  rtc_phase_timer #(
    .T_PHASE (T_PHASE)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .load  (phase_load),
    .last  (phase_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and bus decode; every state change reloads the phase timer.
  always_comb begin
    state_nxt = state;
    bus       = BUS_IDLE;
    ad_out    = '0;
    w_s       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_ADDR_SETUP;
      end
      ST_ADDR_SETUP: begin
        bus.a_d   = 1'b0;
        bus.ad_oe = 1'b1;
        ad_out    = rtc_addr;
        if (phase_last) state_nxt = ST_ADDR_STROBE;
      end
      ST_ADDR_STROBE: begin
        bus.a_d   = 1'b0;
        bus.ad_oe = 1'b1;
        bus.cs_n  = 1'b0;
        bus.wr_n  = 1'b0;
        ad_out    = rtc_addr;
        if (phase_last) state_nxt = ST_ADDR_HOLD;
      end
      ST_ADDR_HOLD: begin
        bus.a_d   = 1'b0;
        bus.ad_oe = 1'b1;
        ad_out    = rtc_addr;
        if (phase_last) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (phase_last) state_nxt = ST_DATA_STROBE;
      end
      ST_DATA_STROBE: begin
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        if (phase_last) state_nxt = ST_DATA_HOLD;
      end
      ST_DATA_HOLD: begin
        if (phase_last) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        w_s       = 1'b1;
        state_nxt = (idx == LAST_IDX) ? ST_IDLE : ST_ADDR_SETUP;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    phase_load = (state_nxt != state);
  end

  // Index, captured byte, bank write bundle and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      data_q    <= '0;
      entrada_q <= '0;
      enable_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_IDLE && start) begin
        idx <= '0;
      end
      if (state == ST_DATA_STROBE && phase_last) begin
        data_q <= ad_in;
      end
      // Bank bundle changes only as WRITE begins, so it holds between writes.
      if (state == ST_DATA_HOLD && phase_last) begin
        entrada_q <= data_q;
        enable_q  <= idx;
      end
      if (state == ST_WRITE) begin
        if (idx == LAST_IDX) begin
          done_q <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign cs_n    = bus.cs_n;
  assign rd_n    = bus.rd_n;
  assign wr_n    = bus.wr_n;
  assign a_d     = bus.a_d;
  assign ad_oe   = bus.ad_oe;
  assign entrada = entrada_q;
  assign enable  = enable_q;
  assign busy    = (state != ST_IDLE);
  assign done    = done_q;

endmodule
